// File: rtl/input_keypad.sv
// Keypad front end: scans a 4x4 active-low key matrix row by row,
// synchronises and debounces the column returns over whole sweeps, and
// strobes key_valid with key_code for each clean single-key press.
module input_keypad #(
    parameter int scan_len = 25000,  // cycles each row stays driven (>= 4)
    parameter int deb_len  = 4       // identical sweeps needed to accept a state (>= 1)
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int DW = (scan_len > 1) ? $clog2(scan_len) : 1;
    localparam int SW = $clog2(deb_len + 1);
    localparam logic [DW-1:0] dwell_last = DW'(scan_len - 1);
    localparam logic [SW-1:0] stable_max = SW'(deb_len);

    logic [3:0]    sync1_reg, sync2_reg;
    logic [1:0]    row_reg;
    logic [DW-1:0] dwell_reg;
    logic [15:0]   snap_reg, prev_reg, accepted_reg;
    logic [SW-1:0] stable_reg;
    logic          key_valid_reg;
    logic [3:0]    key_code_reg;

    logic          last_dwell, sweep_end, accept, press, one_hot;
    logic [15:0]   full_snap;
    logic [SW-1:0] stable_next;
    logic [3:0]    press_code;

    // Row drive is a pure decode of the current row index.
    assign ROW       = ~(4'b0001 << row_reg);
    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;

    assign last_dwell = (dwell_reg == dwell_last);
    assign sweep_end  = last_dwell && (row_reg == 2'd3);
    // Row 3 is sampled on the sweep-end cycle itself, so splice it in live.
    assign full_snap  = {~sync2_reg, snap_reg[11:0]};
    assign one_hot    = (full_snap != 16'h0) && ((full_snap & (full_snap - 16'h1)) == 16'h0);

    // Debounce bookkeeping for the sweep that is ending now.
    always_comb begin
        stable_next = SW'(1);
        if (full_snap == prev_reg) begin
            stable_next = (stable_reg == stable_max) ? stable_reg : stable_reg + 1'b1;
        end
        accept = sweep_end && (stable_next == stable_max);
        press  = accept && (accepted_reg == 16'h0) && one_hot;
    end

    // Index of the single set bit in the snapshot being accepted.
    always_comb begin
        press_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (full_snap[i]) press_code = 4'(i);
        end
    end

    // Two-flop synchroniser for the asynchronous column returns.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_reg <= 4'hF;
            sync2_reg <= 4'hF;
        end else begin
            sync1_reg <= COL;
            sync2_reg <= sync1_reg;
        end
    end

    // Row scan: dwell counter per row, row index wraps 0..3.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            row_reg   <= 2'd0;
            dwell_reg <= '0;
        end else if (last_dwell) begin
            row_reg   <= row_reg + 2'd1;
            dwell_reg <= '0;
        end else begin
            dwell_reg <= dwell_reg + 1'b1;
        end
    end

    // Snapshot capture on each row's last dwell cycle plus sweep-level debounce.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            snap_reg     <= 16'h0;
            prev_reg     <= 16'h0;
            stable_reg   <= '0;
            accepted_reg <= 16'h0;
        end else begin
            if (last_dwell) begin
                snap_reg[{row_reg, 2'b00} +: 4] <= ~sync2_reg;
            end
            if (sweep_end) begin
                prev_reg   <= full_snap;
                stable_reg <= stable_next;
                if (accept) accepted_reg <= full_snap;
            end
        end
    end

    // Press strobe: one cycle, only on an all-zero to single-key transition.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'h0;
        end else begin
            key_valid_reg <= press;
            if (press) key_code_reg <= press_code;
        end
    end

endmodule

// File: tb/tb_input_keypad.sv
// Self-checking bench for input_keypad: a behavioural key matrix answers
// the row drive, and a sweep-level reference model predicts every strobe.
module tb_input_keypad;

    localparam int SCAN  = 4;
    localparam int DEB   = 2;
    localparam int SWEEP = 4 * SCAN;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col;
    logic [3:0] row;
    logic       key_valid;
    logic [3:0] key_code;

    logic [15:0] keys = 16'h0;
    int          cyc;
    int          n_chk = 0;
    int          n_pass = 0;

    // reference model state
    logic [15:0] m_prev, m_acc;
    int          m_cnt;
    int          exp_code[$], exp_cyc[$], obs_code[$], obs_cyc[$];

    input_keypad #(.scan_len(SCAN), .deb_len(DEB)) dut (
        .Clock(clk), .Reset(rst_n), .COL(col),
        .ROW(row), .key_valid(key_valid), .key_code(key_code)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) col = col & ~keys[4*r +: 4];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            obs_code.push_back(int'(key_code));
            obs_cyc.push_back(cyc);
            $display("strobe key_code=%0d at cycle %0d", key_code, cyc);
        end
    end

    task automatic model_reset();
        m_prev = 16'h0; m_acc = 16'h0; m_cnt = 0;
    endtask

    task automatic clear_queues();
        exp_code.delete(); exp_cyc.delete(); obs_code.delete(); obs_cyc.delete();
    endtask

    // One sweep worth of the specification's debounce/press rules.
    task automatic model_sweep(input logic [15:0] snap, input int strobe_cyc);
        if (snap == m_prev) m_cnt = (m_cnt < DEB) ? m_cnt + 1 : DEB;
        else                m_cnt = 1;
        m_prev = snap;
        if (m_cnt == DEB) begin
            if (m_acc == 16'h0 && $countones(snap) == 1) begin
                exp_code.push_back($clog2(snap));
                exp_cyc.push_back(strobe_cyc);
            end
            m_acc = snap;
        end
    endtask

    // Called at a negedge with cyc on a sweep boundary.
    task automatic do_sweeps(input logic [15:0] k, input int n);
        for (int s = 0; s < n; s++) begin
            keys = k;
            model_sweep(k, cyc + SWEEP);
            repeat (SWEEP) @(negedge clk);
        end
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_queues();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if (row !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0)
            $display("FAIL reset_init: row=%b valid=%b code=%0d want 1110/0/0", row, key_valid, key_code);
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
        clear_queues();
        do_sweeps(16'h0020, 3);
        n_chk++;
        if (obs_code.size() != 1 || obs_code[0] != 5)
            $display("FAIL reset_pre_press: got %0d strobes, want 1 with code 5", obs_code.size());
        else n_pass++;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (row !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0)
            $display("FAIL reset_mid: row=%b valid=%b code=%0d want 1110/0/0", row, key_valid, key_code);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_queues();
        do_sweeps(16'h0020, 4);
        n_chk++;
        if (obs_code.size() != exp_code.size() || obs_code.size() != 1)
            $display("FAIL reset_after_count: got %0d strobes, want %0d", obs_code.size(), exp_code.size());
        else n_pass++;
        foreach (exp_code[i]) if (i < obs_code.size()) begin
            n_chk++;
            if (obs_code[i] != exp_code[i] || obs_cyc[i] != exp_cyc[i])
                $display("FAIL reset_after_event: got code %0d cyc %0d, want code %0d cyc %0d",
                         obs_code[i], obs_cyc[i], exp_code[i], exp_cyc[i]);
            else n_pass++;
        end
        do_sweeps(16'h0, 3);
    endtask

    task automatic test_single_press();
        logic [3:0] exp_row;
        keys = 16'h0;
        do_reset(2);
        keys = 16'h0040;
        model_sweep(16'h0040, cyc + SWEEP);
        for (int c = 0; c < SWEEP; c++) begin
            exp_row = ~(4'b0001 << ((cyc / SCAN) % 4));
            n_chk++;
            if (row !== exp_row)
                $display("FAIL row_scan: cycle %0d row=%b want %b", cyc, row, exp_row);
            else n_pass++;
            @(negedge clk);
        end
        do_sweeps(16'h0040, 9);
        n_chk++;
        if (obs_code.size() != 1 || exp_code.size() != 1)
            $display("FAIL single_count: got %0d strobes, want 1 (model %0d)", obs_code.size(), exp_code.size());
        else n_pass++;
        if (obs_code.size() >= 1) begin
            n_chk++;
            if (obs_code[0] != 6 || obs_cyc[0] != 2 * SWEEP)
                $display("FAIL single_event: got code %0d cyc %0d, want code 6 cyc %0d",
                         obs_code[0], obs_cyc[0], 2 * SWEEP);
            else n_pass++;
        end
        n_chk++;
        if (key_code !== 4'd6)
            $display("FAIL single_hold_code: key_code=%0d want 6", key_code);
        else n_pass++;
        clear_queues();
    endtask

    task automatic test_release_repress();
        do_sweeps(16'h0, 3);
        do_sweeps(16'h8000, 3);
        n_chk++;
        if (obs_code.size() != exp_code.size() || obs_code.size() != 1)
            $display("FAIL repress_count: got %0d strobes, want %0d", obs_code.size(), exp_code.size());
        else n_pass++;
        foreach (exp_code[i]) if (i < obs_code.size()) begin
            n_chk++;
            if (obs_code[i] != exp_code[i] || obs_cyc[i] != exp_cyc[i] || obs_code[i] != 15)
                $display("FAIL repress_event: got code %0d cyc %0d, want code %0d cyc %0d",
                         obs_code[i], obs_cyc[i], exp_code[i], exp_cyc[i]);
            else n_pass++;
        end
        do_sweeps(16'h0, 3);
        clear_queues();
    endtask

    task automatic test_chord();
        do_sweeps(16'h0201, 3);
        do_sweeps(16'h0001, 3);
        n_chk++;
        if (obs_code.size() != 0)
            $display("FAIL chord_quiet: got %0d strobes, want 0", obs_code.size());
        else n_pass++;
        do_sweeps(16'h0, 3);
        do_sweeps(16'h0200, 3);
        n_chk++;
        if (obs_code.size() != exp_code.size() || obs_code.size() != 1)
            $display("FAIL chord_count: got %0d strobes, want %0d", obs_code.size(), exp_code.size());
        else n_pass++;
        foreach (exp_code[i]) if (i < obs_code.size()) begin
            n_chk++;
            if (obs_code[i] != exp_code[i] || obs_cyc[i] != exp_cyc[i] || obs_code[i] != 9)
                $display("FAIL chord_event: got code %0d cyc %0d, want code %0d cyc %0d",
                         obs_code[i], obs_cyc[i], exp_code[i], exp_cyc[i]);
            else n_pass++;
        end
        do_sweeps(16'h0, 3);
        clear_queues();
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 6; t++) do_sweeps((t % 2 == 0) ? 16'h0008 : 16'h0000, 1);
        n_chk++;
        if (obs_code.size() != 0)
            $display("FAIL bounce_quiet: got %0d strobes during toggling, want 0", obs_code.size());
        else n_pass++;
        do_sweeps(16'h0008, 3);
        n_chk++;
        if (obs_code.size() != exp_code.size() || obs_code.size() != 1)
            $display("FAIL bounce_count: got %0d strobes, want %0d", obs_code.size(), exp_code.size());
        else n_pass++;
        foreach (exp_code[i]) if (i < obs_code.size()) begin
            n_chk++;
            if (obs_code[i] != exp_code[i] || obs_cyc[i] != exp_cyc[i] || obs_code[i] != 3)
                $display("FAIL bounce_event: got code %0d cyc %0d, want code %0d cyc %0d",
                         obs_code[i], obs_cyc[i], exp_code[i], exp_cyc[i]);
            else n_pass++;
        end
        do_sweeps(16'h0, 3);
        clear_queues();
    endtask

    task automatic test_rollover();
        do_sweeps(16'h0010, 3);
        do_sweeps(16'h0110, 3);
        do_sweeps(16'h0100, 3);
        n_chk++;
        if (obs_code.size() != 1 || obs_code[0] != 4 || exp_code.size() != 1)
            $display("FAIL rollover_first: got %0d strobes, want 1 with code 4", obs_code.size());
        else n_pass++;
        do_sweeps(16'h0, 3);
        do_sweeps(16'h0100, 3);
        n_chk++;
        if (obs_code.size() != exp_code.size() || obs_code.size() != 2)
            $display("FAIL rollover_count: got %0d strobes, want %0d", obs_code.size(), exp_code.size());
        else n_pass++;
        foreach (exp_code[i]) if (i < obs_code.size()) begin
            n_chk++;
            if (obs_code[i] != exp_code[i] || obs_cyc[i] != exp_cyc[i])
                $display("FAIL rollover_event: got code %0d cyc %0d, want code %0d cyc %0d",
                         obs_code[i], obs_cyc[i], exp_code[i], exp_cyc[i]);
            else n_pass++;
        end
        do_sweeps(16'h0, 3);
        clear_queues();
    endtask

    task automatic test_random();
        logic [15:0] k;
        for (int seg = 0; seg < 30; seg++) begin
            case ($urandom_range(0, 2))
                0:       k = 16'h0;
                1:       k = 16'h1 << $urandom_range(0, 15);
                default: k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            do_sweeps(k, $urandom_range(1, 3));
        end
        do_sweeps(16'h0, 3);
        n_chk++;
        if (obs_code.size() != exp_code.size())
            $display("FAIL random_count: got %0d strobes, want %0d", obs_code.size(), exp_code.size());
        else n_pass++;
        foreach (exp_code[i]) if (i < obs_code.size()) begin
            n_chk++;
            if (obs_code[i] != exp_code[i] || obs_cyc[i] != exp_cyc[i])
                $display("FAIL random_event: got code %0d cyc %0d, want code %0d cyc %0d",
                         obs_code[i], obs_cyc[i], exp_code[i], exp_cyc[i]);
            else n_pass++;
        end
        clear_queues();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_release_repress();
        test_chord();
        test_bounce();
        test_rollover();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
